// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: shared states, opcode fields, strobe encodings and opcode classifier for the accumulator sequencer
package acc_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [3:0] {C_ALU, C_EQ, C_MOV, C_JR, C_JMP, C_LWR, C_STR, C_HALT, C_ILL} cls_e;
    localparam logic [2:0] OPC_ALU_REG = 3'b000;
    localparam logic [2:0] OPC_LDST    = 3'b001;
    localparam logic [2:0] OPC_ALU_IMM = 3'b010;
    localparam logic [2:0] OPC_SYS     = 3'b011;
    localparam logic [2:0] OPC_EQ      = 3'b100;
    localparam logic [2:0] OPC_MOV     = 3'b101;
    localparam logic [2:0] OPC_JR      = 3'b110;
    localparam logic [2:0] OPC_JMP     = 3'b111;
    localparam logic [5:0] OP_LWR  = 6'b001000;
    localparam logic [5:0] OP_STR  = 6'b001001;
    localparam logic [5:0] OP_HALT = 6'b011111;
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_ACC = 2'b10;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    function automatic cls_e op_class(input logic [5:0] op);
        case (op[5:3])
            OPC_ALU_REG, OPC_ALU_IMM: op_class = C_ALU;
            OPC_EQ:   op_class = C_EQ;
            OPC_MOV:  op_class = C_MOV;
            OPC_JR:   op_class = C_JR;
            OPC_JMP:  op_class = C_JMP;
            OPC_LDST: op_class = (op == OP_LWR) ? C_LWR : (op == OP_STR) ? C_STR : C_ILL;
            default:  op_class = (op == OP_HALT) ? C_HALT : C_ILL;
        endcase
    endfunction
endpackage

// File: rtl/hs_watchdog.sv
// hs_watchdog: counts unacknowledged request cycles and pulses timeout when the limit would be reached
module hs_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_ack,
    output logic o_timeout
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // wait counter restarts on every state change, idle or ack, otherwise counts a wait cycle
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_cnt <= '0;
        else r_cnt <= (i_clear || !i_active || i_ack) ? '0 : r_cnt + 1'b1;

    assign o_timeout = i_active && !i_ack && (r_cnt == CW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer owning all datapath write strobes
module acc_seq_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    output logic             o_imem_req,
    input  logic             i_imem_ack,
    output logic             o_ir_load,
    input  logic [5:0]       i_op,
    input  logic             i_eq_flag,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    input  logic             i_dmem_ack,
    output logic             o_acc_we,
    output logic             o_rf_we,
    output logic             o_flag_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_busy,
    output logic             o_halted,
    output logic [1:0]       o_err,
    output logic [CNT_W-1:0] o_instr_count
);
    state_e           r_state, w_next;
    cls_e             r_cls, w_dec;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_count;
    logic             w_active, w_ack, w_timeout;

    assign w_dec    = op_class(i_op);
    assign w_active = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ack    = (r_state == S_FETCH) ? i_imem_ack : i_dmem_ack;

    hs_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_next != r_state),
        .i_active  (w_active),
        .i_ack     (w_ack),
        .o_timeout (w_timeout)
    );

    // state register
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_state <= S_IDLE;
        else r_state <= w_next;

    // next-state: ack beats a coincident timeout; HALT is left only through reset
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = i_start ? S_FETCH : S_IDLE;
            S_FETCH:      w_next = i_imem_ack ? S_DECODE : w_timeout ? S_HALT : S_FETCH;
            S_DECODE:     w_next = (w_dec == C_HALT || w_dec == C_ILL) ? S_HALT :
                                   (w_dec == C_LWR || w_dec == C_STR) ? S_MEM : S_EXEC;
            S_EXEC, S_WB: w_next = S_FETCH;
            S_MEM:        w_next = i_dmem_ack ? ((r_cls == C_STR) ? S_FETCH : S_WB) :
                                   w_timeout ? S_HALT : S_MEM;
            default:      w_next = r_state;
        endcase
    end

    // latch the decoded class, record the sticky fault cause, count retired instructions
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_cls   <= C_ALU;
            r_err   <= ERR_NONE;
            r_count <= '0;
        end else begin
            if (r_state == S_DECODE) r_cls <= w_dec;
            if (r_state == S_DECODE && w_dec == C_ILL) r_err <= ERR_ILL;
            else if (w_timeout) r_err <= ERR_TMO;
            r_count <= r_count + CNT_W'(o_pc_we);
        end

    // strobes from state and latched class; store retire and JMP select also follow ack/eq_flag in their cycle
    always_comb begin
        o_imem_req    = r_state == S_FETCH;
        o_ir_load     = (r_state == S_FETCH) && i_imem_ack;
        o_dmem_req    = r_state == S_MEM;
        o_dmem_we     = (r_state == S_MEM) && (r_cls == C_STR);
        o_acc_we      = ((r_state == S_EXEC) && (r_cls == C_ALU)) || (r_state == S_WB);
        o_rf_we       = (r_state == S_EXEC) && (r_cls == C_MOV);
        o_flag_we     = (r_state == S_EXEC) && (r_cls == C_EQ);
        o_pc_we       = (r_state == S_EXEC) || (r_state == S_WB) || (o_dmem_we && i_dmem_ack);
        o_pc_sel      = (r_state != S_EXEC) ? PC_INC : (r_cls == C_JR) ? PC_ACC :
                        (r_cls == C_JMP && i_eq_flag) ? PC_BR : PC_INC;
        o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
        o_halted      = r_state == S_HALT;
        o_err         = r_err;
        o_instr_count = r_count;
    end
endmodule
